// File: rtl/stream_packetizer.sv
// rtl/stream_packetizer.sv - frames a raw beat stream into dest/last packets from (dest, len) commands
module stream_packetizer #(
  parameter int T_DATA_WIDTH = 8,
  parameter int M_DATA_COUNT = 3,
  parameter int LEN_WIDTH    = 8,
  localparam int T_DEST_WIDTH = (M_DATA_COUNT == 1) ? 1 : $clog2(M_DATA_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DEST_WIDTH-1:0] cmd_dest_i,
  input  logic [LEN_WIDTH-1:0]    cmd_len_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [T_DATA_WIDTH-1:0] in_data_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_DEST_WIDTH-1:0] m_dest_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    drop_err_o,
  output logic                    busy_o
);

  // One extra bit so the legality compare works when M_DATA_COUNT is a power of two.
  localparam logic [T_DEST_WIDTH:0] DEST_LIMIT = M_DATA_COUNT[T_DEST_WIDTH:0];

  typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;

  state_t                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    cnt_q;
  logic [T_DEST_WIDTH-1:0] dest_q;
  logic                    cnt_zero;
  logic                    dest_legal;
  logic                    cmd_fire;
  logic                    beat_fire;
  logic                    load;

  assign cnt_zero   = (cnt_q == '0);
  assign dest_legal = ({1'b0, cmd_dest_i} < DEST_LIMIT);
  assign busy_o     = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    cmd_fire    = 1'b0;
    beat_fire   = 1'b0;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          cmd_fire = 1'b1;
          state_d  = dest_legal ? SEND : DROP;
        end
      end
      SEND: begin
        // The output stage can take a beat if empty or emptying this cycle.
        in_ready_o = !m_valid_o || m_ready_i;
        if (in_valid_i && in_ready_o) begin
          beat_fire = 1'b1;
          load      = 1'b1;
          if (cnt_zero) state_d = IDLE;
        end
      end
      DROP: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          beat_fire = 1'b1;
          if (cnt_zero) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dest_q     <= '0;
      drop_err_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_err_o <= cmd_fire && !dest_legal;
      if (cmd_fire) begin
        cnt_q  <= cmd_len_i;
        dest_q <= cmd_dest_i;
      end else if (beat_fire && !cnt_zero) begin
        cnt_q <= cnt_q - LEN_WIDTH'(1);
      end
    end
  end

  // Output register: holds steady under backpressure, reloads while unloading.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      m_data_o  <= '0;
      m_dest_o  <= '0;
    end else if (load) begin
      m_valid_o <= 1'b1;
      m_last_o  <= cnt_zero;
      m_data_o  <= in_data_i;
      m_dest_o  <= dest_q;
    end else if (m_ready_i) begin
      m_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_packetizer.sv
// tb/tb_stream_packetizer.sv - directed bench with a packet-level reference model
module tb_stream_packetizer;
  localparam int DW  = 8;
  localparam int MC  = 3;
  localparam int LW  = 4;
  localparam int DSW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [DSW-1:0] cmd_dest_i;
  logic [LW-1:0]  cmd_len_i;
  logic           cmd_valid_i;
  logic           cmd_ready_o;
  logic [DW-1:0]  in_data_i;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [DW-1:0]  m_data_o;
  logic [DSW-1:0] m_dest_o;
  logic           m_last_o;
  logic           m_valid_o;
  logic           m_ready_i;
  logic           drop_err_o;
  logic           busy_o;

  always #5 clk = ~clk;

  stream_packetizer #(.T_DATA_WIDTH(DW), .M_DATA_COUNT(MC), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_dest_i(cmd_dest_i), .cmd_len_i(cmd_len_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .m_data_o(m_data_o), .m_dest_o(m_dest_o), .m_last_o(m_last_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .drop_err_o(drop_err_o), .busy_o(busy_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for handshake (t=%0t)", name, $time);
  endtask

  // Reference model: packet state plus a queue of beats owed to the output.
  typedef struct packed {
    logic [DW-1:0]  d;
    logic [DSW-1:0] dst;
    logic           lst;
  } beat_t;

  beat_t          exp_q[$];
  beat_t          nb;
  int             m_phase = 0;
  int             m_rem   = 0;
  logic [DSW-1:0] m_dest  = '0;
  bit             m_drop_flag = 1'b0;
  bit             post_reset  = 1'b0;
  bit             exp_in_rdy;

  logic [DW-1:0]  log_d[$];
  logic [DSW-1:0] log_dst[$];
  logic           log_lst[$];
  int             n_drop = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase     = 0;
      m_rem       = 0;
      m_drop_flag = 1'b0;
      exp_q.delete();
      post_reset  = 1'b1;
    end else begin
      if (post_reset) begin
        chk("reset_data", 32'(m_data_o), 0);
        chk("reset_dest", 32'(m_dest_o), 0);
        chk("reset_last", 32'(m_last_o), 0);
        post_reset = 1'b0;
      end
      exp_in_rdy = (m_phase == 1) ? (exp_q.size() == 0 || m_ready_i) : (m_phase == 2);
      chk("cmd_ready", 32'(cmd_ready_o), 32'(m_phase == 0));
      chk("busy", 32'(busy_o), 32'(m_phase != 0));
      chk("in_ready", 32'(in_ready_o), 32'(exp_in_rdy));
      chk("m_valid", 32'(m_valid_o), 32'(exp_q.size() > 0));
      chk("drop_err", 32'(drop_err_o), 32'(m_drop_flag));
      if (exp_q.size() > 0) begin
        chk("m_data", 32'(m_data_o), 32'(exp_q[0].d));
        chk("m_dest", 32'(m_dest_o), 32'(exp_q[0].dst));
        chk("m_last", 32'(m_last_o), 32'(exp_q[0].lst));
      end
      if (drop_err_o === 1'b1) n_drop++;
      if (m_valid_o === 1'b1 && m_ready_i) begin
        log_d.push_back(m_data_o);
        log_dst.push_back(m_dest_o);
        log_lst.push_back(m_last_o);
      end
      m_drop_flag = 1'b0;
      if (exp_q.size() > 0 && m_ready_i) void'(exp_q.pop_front());
      if (m_phase == 0) begin
        if (cmd_valid_i) begin
          m_rem  = int'(cmd_len_i) + 1;
          m_dest = cmd_dest_i;
          if (int'(cmd_dest_i) < MC) m_phase = 1;
          else begin
            m_phase     = 2;
            m_drop_flag = 1'b1;
          end
        end
      end else if (in_valid_i && exp_in_rdy) begin
        if (m_phase == 1) begin
          nb.d   = in_data_i;
          nb.dst = m_dest;
          nb.lst = (m_rem == 1);
          exp_q.push_back(nb);
        end
        m_rem--;
        if (m_rem == 0) m_phase = 0;
      end
    end
  end

  bit rdy_toggle = 1'b0;
  bit rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  initial begin
    int k;
    k = 0;
    m_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready_i = rdy_toggle ? rdy_pat[k % 4] : 1'b1;
      k++;
    end
  end

  task automatic send_cmd(input logic [DSW-1:0] d, input logic [LW-1:0] l);
    int t;
    t = 0;
    cmd_dest_i  = d;
    cmd_len_i   = l;
    cmd_valid_i = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!cmd_ready_o && t < 100);
    if (!cmd_ready_o) timeout_fail("cmd_handshake");
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic send_data(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      in_data_i  = base + DW'(i);
      in_valid_i = 1'b1;
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready_o && t < 100);
      if (!in_ready_o) timeout_fail("in_handshake");
      @(posedge clk);
      #1;
    end
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    rdy_toggle = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_d.delete();
    log_dst.delete();
    log_lst.delete();
  endtask

  task automatic check_pkt(input string nm, input int start, input int n,
                           input logic [DW-1:0] base, input logic [DSW-1:0] dst);
    for (int i = 0; i < n; i++) begin
      if (start + i >= log_d.size()) begin
        chk({nm, "_missing_beat"}, 32'(log_d.size()), 32'(start + n));
        return;
      end
      chk({nm, "_data"}, 32'(log_d[start+i]), 32'(base + DW'(i)));
      chk({nm, "_dest"}, 32'(log_dst[start+i]), 32'(dst));
      chk({nm, "_last"}, 32'(log_lst[start+i]), 32'(i == n - 1));
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    cmd_dest_i  = '0;
    cmd_len_i   = '0;
    cmd_valid_i = 1'b0;
    in_data_i   = '0;
    in_valid_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: basic 4-beat packet to dest 2
    clear_log();
    send_cmd(2'd2, 4'd3);
    send_data(4, 8'hA0);
    chk("t1_busy_after_last", 32'(busy_o), 0);
    chk("t1_last_in_reg", 32'(m_last_o), 1);
    drain();
    chk("t1_count", 32'(log_d.size()), 4);
    check_pkt("t1", 0, 4, 8'hA0, 2'd2);

    // 2: same packet under 1,0,0,1 backpressure
    clear_log();
    rdy_toggle = 1'b1;
    send_cmd(2'd2, 4'd3);
    send_data(4, 8'hB0);
    drain();
    chk("t2_count", 32'(log_d.size()), 4);
    check_pkt("t2", 0, 4, 8'hB0, 2'd2);

    // 3: illegal dest dropped, then a single-beat packet
    clear_log();
    n_drop = 0;
    send_cmd(2'd3, 4'd1);
    send_data(2, 8'hC0);
    send_cmd(2'd0, 4'd0);
    send_data(1, 8'hD0);
    drain();
    chk("t3_drop_pulses", 32'(n_drop), 1);
    chk("t3_count", 32'(log_d.size()), 1);
    check_pkt("t3", 0, 1, 8'hD0, 2'd0);

    // 4: back-to-back single-beat packets to every dest
    clear_log();
    for (int d = 0; d < 3; d++) begin
      send_cmd(DSW'(d), 4'd0);
      send_data(1, 8'hE0 + DW'(d));
    end
    drain();
    chk("t4_count", 32'(log_d.size()), 3);
    for (int d = 0; d < 3; d++) check_pkt("t4", d, 1, 8'hE0 + DW'(d), DSW'(d));

    // 5: reset mid-packet aborts it, next packet framed cleanly
    clear_log();
    send_cmd(2'd1, 4'd7);
    send_data(2, 8'hF0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t5_valid", 32'(m_valid_o), 0);
    chk("t5_last", 32'(m_last_o), 0);
    chk("t5_cmd_ready", 32'(cmd_ready_o), 1);
    chk("t5_busy", 32'(busy_o), 0);
    chk("t5_drop", 32'(drop_err_o), 0);
    send_cmd(2'd2, 4'd1);
    send_data(2, 8'h10);
    drain();
    chk("t5_count", 32'(log_d.size()), 3);
    if (log_d.size() >= 1) begin
      chk("t5_pre_data", 32'(log_d[0]), 32'h0F0);
      chk("t5_pre_last", 32'(log_lst[0]), 0);
    end
    check_pkt("t5_new", 1, 2, 8'h10, 2'd2);

    // 6: maximum length gives 16 beats
    clear_log();
    send_cmd(2'd1, 4'd15);
    send_data(16, 8'h60);
    drain();
    chk("t6_count", 32'(log_d.size()), 16);
    check_pkt("t6", 0, 16, 8'h60, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
